// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - MD_* operation codes presented on md_op by the decode stage
//   - md_state_e : controller state encoding
//   - md_abs     : two's-complement magnitude helper
package mips_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [4:0] MD_LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        MD_S_IDLE = 2'd0,
        MD_S_RUN  = 2'd1,
        MD_S_FIX  = 2'd2
    } md_state_e;

    // 32'h80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit owning the architectural HI/LO.
//
// State table
//   state | meaning
//   IDLE  | accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues
//   RUN   | 32 iterations, one bit per cycle, cnt_q 0..31
//   FIX   | sign correction, HI/LO write, md_done pulse
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   md_start, md_op : issue strobe and operation code (MD_* constants)
//   md_x, md_y      : rs / rt operands
//   md_busy         : iterative operation in flight (registered)
//   md_done         : one-cycle pulse after HI/LO written by an iterative op
//   hi, lo          : architectural HI/LO registers
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] md_x,
    input  logic [XLEN-1:0] md_y,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;   // product upper half / partial remainder
    logic [31:0] acc_lo_q, acc_lo_d;   // multiplier shifting out / quotient shifting in
    logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;   // negate product (mul) or quotient (div)
    logic        neg_hi_q, neg_hi_d;   // negate remainder (div only)
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Shared 33-bit adder: add for shift-add, add-complement for restoring subtract.
    logic [32:0] add_a, add_b;
    logic        add_cin;
    logic [33:0] add_res;

    always_comb begin
        add_a   = {1'b0, acc_hi_q};
        add_b   = acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0;
        add_cin = 1'b0;
        if (is_div_q) begin
            add_a   = {acc_hi_q, acc_lo_q[31]};
            add_b   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end
    end

    // Carry out of the subtract means the shifted remainder >= divisor.
    assign add_res = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_cin};

    logic        iss_signed, iss_div, iss_mul, iss_zdiv;
    logic [31:0] x_mag, y_mag;
    logic [63:0] prod;

    always_comb begin
        iss_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
        iss_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
        iss_mul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
        // Divide by zero returns raw unsigned results, so signs are left alone.
        iss_zdiv   = iss_div && (md_y == 32'd0);
        x_mag      = (iss_signed && !iss_zdiv) ? md_abs(md_x) : md_x;
        y_mag      = iss_signed ? md_abs(md_y) : md_y;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod     = {acc_hi_q, acc_lo_q};

        case (state_q)
            MD_S_IDLE: begin
                if (md_start) begin
                    if (iss_mul || iss_div) begin
                        state_d  = MD_S_RUN;
                        cnt_d    = 5'd0;
                        busy_d   = 1'b1;
                        is_div_d = iss_div;
                        acc_hi_d = 32'd0;
                        acc_lo_d = iss_div ? x_mag : y_mag;
                        opnd_d   = iss_div ? y_mag : x_mag;
                        neg_lo_d = iss_signed && !iss_zdiv && (md_x[31] ^ md_y[31]);
                        neg_hi_d = iss_signed && !iss_zdiv && iss_div && md_x[31];
                    end else if (md_op == MD_MTHI) begin
                        hi_d = md_x;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = md_x;
                    end
                end
            end

            MD_S_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = add_res[33] ? add_res[31:0] : {acc_hi_q[30:0], acc_lo_q[31]};
                    acc_lo_d = {acc_lo_q[30:0], add_res[33]};
                end else begin
                    acc_hi_d = add_res[32:1];
                    acc_lo_d = {add_res[0], acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == MD_LAST_ITER) begin
                    state_d = MD_S_FIX;
                end
            end

            MD_S_FIX: begin
                if (is_div_q) begin
                    hi_d = neg_hi_q ? (32'd0 - acc_hi_q) : acc_hi_q;
                    lo_d = neg_lo_q ? (32'd0 - acc_lo_q) : acc_lo_q;
                end else begin
                    if (neg_lo_q) begin
                        prod = 64'd0 - {acc_hi_q, acc_lo_q};
                    end
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = MD_S_IDLE;
            end

            default: begin
                state_d = MD_S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_S_IDLE;
            cnt_q    <= 5'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            opnd_q   <= 32'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
